// File: rtl/crc_pkg.sv
// Shared definitions for the streaming CRC engine: polynomial table, byte-lane
// reflection helper and FSM state type.
package crc_pkg;

   localparam logic [32:0] POLY_PARITY  = 33'h0_0000_0003;
   localparam logic [32:0] POLY_ITU4    = 33'h0_0000_0013;
   localparam logic [32:0] POLY_USB5    = 33'h0_0000_0025;
   localparam logic [32:0] POLY_ITU6    = 33'h0_0000_0043;
   localparam logic [32:0] POLY_SD7     = 33'h0_0000_0089;
   localparam logic [32:0] POLY_WCDMA8  = 33'h0_0000_019B;
   localparam logic [32:0] POLY_ATM10   = 33'h0_0000_0633;
   localparam logic [32:0] POLY_CRC12   = 33'h0_0000_180F;
   localparam logic [32:0] POLY_CAN15   = 33'h0_0000_C599;
   localparam logic [32:0] POLY_ANSI16  = 33'h0_0001_8005;
   localparam logic [32:0] POLY_MODES24 = 33'h0_01FF_F409;
   localparam logic [32:0] POLY_IEEE32  = 33'h1_04C1_1DB7;

   localparam int REFLECT_MAX = 512;

   typedef enum logic {IDLE, ACCUM} crc_state_e;

   // Returns the full polynomial including the x^bits term; zero marks an
   // unsupported width.
   function automatic logic [32:0] crc_poly(int bits);
      case (bits)
         1:       return POLY_PARITY;
         4:       return POLY_ITU4;
         5:       return POLY_USB5;
         6:       return POLY_ITU6;
         7:       return POLY_SD7;
         8:       return POLY_WCDMA8;
         10:      return POLY_ATM10;
         12:      return POLY_CRC12;
         15:      return POLY_CAN15;
         16:      return POLY_ANSI16;
         24:      return POLY_MODES24;
         32:      return POLY_IEEE32;
         default: return 33'h0;
      endcase
   endfunction

   function automatic logic [REFLECT_MAX-1:0] reflect_bytes(logic [REFLECT_MAX-1:0] data);
      logic [REFLECT_MAX-1:0] res;
      res = '0;
      for (int b = 0; b < REFLECT_MAX / 8; b++) begin
         for (int i = 0; i < 8; i++) begin
            res[b*8 + i] = data[b*8 + 7 - i];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/crc_step.sv
// One-beat parallel CRC update, MSB-first over the beat; purely combinational.
module crc_step
   import crc_pkg::*;
#(
   parameter int DATA_WIDTH      = 8,
   parameter int POLYNOMIAL_BITS = 32
) (
   input  logic [POLYNOMIAL_BITS-1:0] crc_in,
   input  logic [DATA_WIDTH-1:0]      data_in,
   output logic [POLYNOMIAL_BITS-1:0] crc_out
);

   localparam logic [32:0] POLY_FULL = crc_poly(POLYNOMIAL_BITS);
   localparam logic [POLYNOMIAL_BITS-1:0] POLY = POLY_FULL[POLYNOMIAL_BITS-1:0];

   always_comb begin
      crc_out = crc_in;
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
         if (data_in[i] ^ crc_out[POLYNOMIAL_BITS-1]) begin
            crc_out = (crc_out << 1) ^ POLY;
         end else begin
            crc_out = crc_out << 1;
         end
      end
   end

endmodule

// File: rtl/crc_stream.sv
// Frame-based streaming CRC engine with valid/ready on both sides and a
// registered, backpressured result.
//
// state | meaning
// IDLE  | between frames; a sof beat starts a frame, others are protocol errors
// ACCUM | inside a frame; beats accumulate until eof, a sof restarts the frame
module crc_stream
   import crc_pkg::*;
#(
   parameter int                         DATA_WIDTH      = 8,
   parameter int                         POLYNOMIAL_BITS = 32,
   parameter logic [POLYNOMIAL_BITS-1:0] INIT            = '1,
   parameter logic [POLYNOMIAL_BITS-1:0] XOR_OUT         = '1,
   parameter bit                         REFLECT_IN      = 1'b1,
   parameter bit                         REFLECT_OUT     = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [DATA_WIDTH-1:0]      s_data,
   input  logic                       s_sof,
   input  logic                       s_eof,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [POLYNOMIAL_BITS-1:0] m_crc,
   output logic                       proto_err
);

   if (crc_poly(POLYNOMIAL_BITS) == 33'h0) begin : g_bad_width
      $error("crc_stream: unsupported POLYNOMIAL_BITS");
   end
   if (REFLECT_IN && (DATA_WIDTH % 8 != 0)) begin : g_bad_reflect
      $error("crc_stream: REFLECT_IN needs DATA_WIDTH to be a multiple of 8");
   end

   crc_state_e                 state_q;
   logic [POLYNOMIAL_BITS-1:0] crc_q;
   logic [POLYNOMIAL_BITS-1:0] crc_seed;
   logic [POLYNOMIAL_BITS-1:0] crc_next;
   logic [POLYNOMIAL_BITS-1:0] crc_rev;
   logic [POLYNOMIAL_BITS-1:0] result;
   logic [DATA_WIDTH-1:0]      beat_data;
   logic                       accept;
   logic                       take_beat;
   logic                       bad_beat;

   assign s_ready   = !(m_valid && !m_ready);
   assign accept    = s_valid && s_ready;
   assign take_beat = accept && (s_sof || state_q == ACCUM);
   assign bad_beat  = accept && ((state_q == IDLE) ? !s_sof : s_sof);

   assign beat_data = REFLECT_IN ? DATA_WIDTH'(reflect_bytes(REFLECT_MAX'(s_data))) : s_data;
   // A sof beat always seeds from INIT, which also covers the mid-frame restart.
   assign crc_seed  = s_sof ? INIT : crc_q;

   crc_step #(
      .DATA_WIDTH      (DATA_WIDTH),
      .POLYNOMIAL_BITS (POLYNOMIAL_BITS)
   ) u_step (
      .crc_in  (crc_seed),
      .data_in (beat_data),
      .crc_out (crc_next)
   );

   always_comb begin
      crc_rev = '0;
      for (int i = 0; i < POLYNOMIAL_BITS; i++) begin
         crc_rev[i] = crc_next[POLYNOMIAL_BITS-1-i];
      end
      result = (REFLECT_OUT ? crc_rev : crc_next) ^ XOR_OUT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         crc_q     <= INIT;
         m_valid   <= 1'b0;
         m_crc     <= '0;
         proto_err <= 1'b0;
      end else begin
         proto_err <= bad_beat;
         if (take_beat) begin
            crc_q   <= crc_next;
            state_q <= s_eof ? IDLE : ACCUM;
         end
         if (take_beat && s_eof) begin
            m_valid <= 1'b1;
            m_crc   <= result;
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_crc_stream.sv
// Directed bench for crc_stream: four configurations share one stimulus stream.
module tb_crc_stream;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       s_valid = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       s_sof = 1'b0;
   logic       s_eof = 1'b0;
   logic       m_ready = 1'b1;

   logic        s_ready32, m_valid32, perr32;
   logic [31:0] m_crc32;
   logic        s_ready16, m_valid16, perr16;
   logic [15:0] m_crc16;
   logic        s_ready8, m_valid8, perr8;
   logic [7:0]  m_crc8;
   logic        s_ready1, m_valid1, perr1;
   logic [0:0]  m_crc1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   crc_stream u_crc32 (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready32),
      .s_data(s_data), .s_sof(s_sof), .s_eof(s_eof), .m_valid(m_valid32),
      .m_ready(m_ready), .m_crc(m_crc32), .proto_err(perr32)
   );

   crc_stream #(.POLYNOMIAL_BITS(16), .INIT(16'h0000), .XOR_OUT(16'h0000)) u_crc16 (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready16),
      .s_data(s_data), .s_sof(s_sof), .s_eof(s_eof), .m_valid(m_valid16),
      .m_ready(m_ready), .m_crc(m_crc16), .proto_err(perr16)
   );

   crc_stream #(.POLYNOMIAL_BITS(8), .INIT(8'h00), .XOR_OUT(8'h00),
                .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0)) u_crc8 (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready8),
      .s_data(s_data), .s_sof(s_sof), .s_eof(s_eof), .m_valid(m_valid8),
      .m_ready(m_ready), .m_crc(m_crc8), .proto_err(perr8)
   );

   crc_stream #(.POLYNOMIAL_BITS(1), .INIT(1'b0), .XOR_OUT(1'b0),
                .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0)) u_crc1 (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready1),
      .s_data(s_data), .s_sof(s_sof), .s_eof(s_eof), .m_valid(m_valid1),
      .m_ready(m_ready), .m_crc(m_crc1), .proto_err(perr1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one beat for one edge; returns #1 after that edge.
   task automatic beat(input logic [7:0] d, input logic sof, input logic eof);
      s_valid = 1'b1;
      s_data  = d;
      s_sof   = sof;
      s_eof   = eof;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      s_valid = 1'b0;
      s_sof   = 1'b0;
      s_eof   = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         beat(s[i], i == 0, i == s.len() - 1);
      end
      s_valid = 1'b0;
   endtask

   task automatic do_reset();
      s_valid = 1'b0;
      m_ready = 1'b1;
      rst_n   = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      // reset state
      #1 rst_n = 1'b0;
      #1;
      check("rst_m_valid", 32'(m_valid32), 32'd0);
      check("rst_m_crc", m_crc32, 32'd0);
      check("rst_perr", 32'(perr32), 32'd0);
      check("rst_s_ready", 32'(s_ready32), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // CRC-32 and CRC-16/ARC of the check string
      send_str("123456789");
      check("crc32_valid", 32'(m_valid32), 32'd1);
      check("crc32_value", m_crc32, 32'hCBF43926);
      check("crc16_value", 32'(m_crc16), 32'h0000BB3D);
      idle();
      check("crc32_drained", 32'(m_valid32), 32'd0);

      // back-to-back single-beat frames
      do_reset();
      beat(8'h00, 1'b1, 1'b1);
      check("crc8_f0_valid", 32'(m_valid8), 32'd1);
      check("crc8_f0", 32'(m_crc8), 32'h00);
      check("crc1_f0", 32'(m_crc1), 32'd0);
      beat(8'h01, 1'b1, 1'b1);
      check("crc8_f1_valid", 32'(m_valid8), 32'd1);
      check("crc8_f1", 32'(m_crc8), 32'h9B);
      check("crc1_f1", 32'(m_crc1), 32'd1);
      beat(8'h03, 1'b1, 1'b1);
      check("crc8_f3", 32'(m_crc8), 32'h36);
      check("crc1_f3", 32'(m_crc1), 32'd0);
      idle();

      // backpressure: held result stalls input, then simultaneous take and load
      do_reset();
      m_ready = 1'b0;
      beat(8'h01, 1'b1, 1'b1);
      check("stall_valid", 32'(m_valid1), 32'd1);
      check("stall_crc", 32'(m_crc1), 32'd1);
      s_valid = 1'b1;
      s_data  = 8'h03;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("stall_s_ready", 32'(s_ready1), 32'd0);
         check("stall_hold_crc", 32'(m_crc1), 32'd1);
      end
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      check("swap_valid", 32'(m_valid1), 32'd1);
      check("swap_crc", 32'(m_crc1), 32'd0);
      idle();
      check("swap_drained", 32'(m_valid1), 32'd0);

      // protocol errors
      do_reset();
      beat(8'h55, 1'b0, 1'b0);
      check("nosof_perr", 32'(perr32), 32'd1);
      check("nosof_no_valid", 32'(m_valid32), 32'd0);
      idle();
      check("nosof_perr_pulse", 32'(perr32), 32'd0);
      beat("1", 1'b1, 1'b0);
      check("sof_first_perr", 32'(perr32), 32'd0);
      beat("2", 1'b0, 1'b0);
      beat("1", 1'b1, 1'b0);
      check("midsof_perr", 32'(perr32), 32'd1);
      begin
         string rest = "23456789";
         for (int i = 0; i < rest.len(); i++) begin
            beat(rest[i], 1'b0, i == rest.len() - 1);
            if (i == 0) check("midsof_perr_pulse", 32'(perr32), 32'd0);
         end
      end
      check("midsof_crc", m_crc32, 32'hCBF43926);
      idle();

      // async reset with a held result and a pending error pulse
      m_ready = 1'b0;
      beat("9", 1'b1, 1'b0);
      beat("8", 1'b0, 1'b0);
      beat("7", 1'b1, 1'b1);
      check("pre_rst_perr", 32'(perr32), 32'd1);
      check("pre_rst_valid", 32'(m_valid32), 32'd1);
      s_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(m_valid32), 32'd0);
      check("async_rst_perr", 32'(perr32), 32'd0);
      check("async_rst_crc", m_crc32, 32'd0);
      check("async_rst_s_ready", 32'(s_ready32), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      m_ready = 1'b1;

      // reset mid-frame, then a clean frame
      beat("5", 1'b1, 1'b0);
      beat("5", 1'b0, 1'b0);
      s_valid = 1'b0;
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      send_str("123456789");
      check("post_rst_valid", 32'(m_valid32), 32'd1);
      check("post_rst_crc", m_crc32, 32'hCBF43926);
      check("post_rst_crc16", 32'(m_crc16), 32'h0000BB3D);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/crc_stream.md
# crc_stream

Streaming, frame-based CRC engine: accumulates a CRC over a multi-beat frame delimited by start/end-of-frame flags, using valid/ready handshakes on input and output. It generalises the single-beat parallel CRC generator with these additions:
- cross-beat accumulation
- configurable init value, bit reflection and final XOR
- registered result with backpressure
- protocol error reporting

It sits between a packet source and the checker/inserter logic of the data path.

## Interface
Parameters:
- DATA_WIDTH, 8, beat width in bits; must be a multiple of 8 when REFLECT_IN=1.
- POLYNOMIAL_BITS, 32, CRC width. Supported values are 1, 4, 5, 6, 7, 8, 10, 12, 15, 16, 24 and 32; any other value is an elaboration-time error.
- INIT, '1, initial CRC register value (POLYNOMIAL_BITS wide).
- XOR_OUT, '1, value XORed onto the final CRC.
- REFLECT_IN, 1, when 1, bit-reverse each byte lane of s_data before the update.
- REFLECT_OUT, 1, when 1, bit-reverse the whole CRC register before XOR_OUT.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  DATA_WIDTH  beat data.
- s_sof  in  1  beat is the first beat of a frame.
- s_eof  in  1  beat is the last beat of a frame; may coincide with s_sof.
- m_valid  out  1  final CRC valid.
- m_ready  in  1  downstream accepts m_crc.
- m_crc  out  POLYNOMIAL_BITS  final CRC of the last completed frame.
- proto_err  out  1  one-cycle pulse on a protocol violation.

## Operation
CRC update per beat:
- The register is processed MSB-first over the (optionally reflected) beat.
- Processing goes from data bit DATA_WIDTH-1 down to 0.
- For each bit: d = data_bit ^ crc[P-1]; crc = (crc << 1) ^ (d ? poly[P-1:0] : 0).
- poly is the standard polynomial for POLYNOMIAL_BITS: PARITY, CCITT, USB, ITU, SD, WCDMA, ATM, CRC-12, CAN, ANSI-16, MODE-S or IEEE-32.

The FSM has two states:
- **IDLE:**
  - An accepted beat with s_sof loads crc = update(INIT, beat).
  - If the beat also has s_eof, the result is produced and the FSM stays in IDLE; otherwise it moves to ACCUM.
  - An accepted beat without s_sof is discarded and pulses proto_err.
- **ACCUM:**
  - An accepted beat without s_sof updates crc = update(crc, beat).
  - If that beat has s_eof, the result is produced and the FSM goes to IDLE.
  - An accepted beat with s_sof abandons the current frame, pulses proto_err and restarts from INIT with that beat, using the same sof/eof rules as IDLE.

Result production:
- m_crc <= (REFLECT_OUT ? reverse(crc_next) : crc_next) ^ XOR_OUT, and m_valid <= 1.
- m_valid stays high with m_crc stable until m_valid && m_ready.

Backpressure:
- s_ready = !(m_valid && !m_ready), combinational from registered state plus m_ready.
- A held result therefore stalls input only while it is unaccepted. A new frame may accumulate while a result is being taken.

Reset:
- Asynchronous assertion returns the FSM to IDLE and discards any partial frame.
- Reset values: m_valid=0, m_crc=0, proto_err=0, crc register=INIT. s_ready evaluates to 1.

## Timing
- Throughput: one beat per cycle, with no bubbles between frames.
- Latency: eof beat accepted at edge N, then m_valid=1 and m_crc valid after edge N; visible in cycle N+1.
- Simultaneous eof acceptance and m_ready with m_valid=1: the old result is consumed and the new one loaded on the same edge, so m_valid stays 1.
- proto_err is registered: it is high for exactly the cycle after the offending beat is accepted.
- s_valid with s_ready=0: no state change. Sources must hold the beat; the block does not check this.

## Structure
- crc_pkg contains:
  - the 33-bit polynomial constants;
  - function crc_poly(int bits) returning the polynomial;
  - function reflect_bytes;
  - typedef enum logic {IDLE, ACCUM} crc_state_e.
- Sub-module crc_step is purely combinational: (crc_in, data_in) -> crc_out, one beat, parametrised on DATA_WIDTH and POLYNOMIAL_BITS.
- crc_stream holds the FSM, the CRC register and the output register.

## Test plan
- CRC-32 with defaults (DATA_WIDTH=8, reflect on, INIT and XOR_OUT all ones): ASCII "123456789" as 9 beats (sof on the first, eof on the last) -> m_crc=0xCBF43926, one cycle after the eof beat.
- POLYNOMIAL_BITS=16, INIT=0, XOR_OUT=0, reflect on: "123456789" -> m_crc=0xBB3D.
- POLYNOMIAL_BITS=8, INIT=0, XOR_OUT=0, reflect off: single beat 0x01 with sof+eof -> 0x9B. Back-to-back single-beat frames 0x00 and 0x01 in consecutive cycles -> 0x00 then 0x9B, with m_ready tied high.
- POLYNOMIAL_BITS=1, INIT=0, XOR_OUT=0, reflect off: frames 0x01 -> 1 and 0x03 -> 0. Hold m_ready=0 for 5 cycles -> m_crc stable, s_ready=0, next beat not consumed.
- Protocol errors:
  - a beat without sof in IDLE -> proto_err pulse, no m_valid;
  - sof mid-frame -> proto_err pulse, and the CRC equals that of the new frame alone.
- Assert rst_n mid-frame, release, then send "123456789" -> correct CRC, with no residue from the aborted frame. m_valid=0 and proto_err=0 immediately on reset assertion.
